// File: rtl/motor_sequencer_if.sv
// Command handshake bundle for motor_sequencer: the command source drives
// valid/motor/dir/duty, and the sequencer returns ready.
interface motor_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_motor;
  logic [1:0] cmd_dir;
  logic [7:0] cmd_duty;

  modport master (
    output cmd_valid, cmd_motor, cmd_dir, cmd_duty,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_motor, cmd_dir, cmd_duty,
    output cmd_ready
  );
endinterface

// File: rtl/motor_sequencer.sv
// Two-channel H-bridge sequencer. It ramps PWM duty linearly and inserts a
// dead interval before every direction change, brake or coast.
module motor_sequencer #(
  parameter int unsigned RAMP_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  motor_sequencer_if.slave        cmd,
  input  logic                    estop,
  output logic [3:0]              IN,
  output logic [1:0]              EN,
  output logic [1:0]              busy
);

  typedef enum logic [1:0] {STOP, RUN, DEAD, BRAKE} state_t;
  typedef enum logic [1:0] {D_COAST = 2'b00, D_FWD = 2'b01, D_REV = 2'b10, D_BRAKE = 2'b11} dir_t;

  localparam int unsigned   PW        = $clog2(RAMP_DIV + 1);
  localparam int unsigned   DW        = $clog2(DEAD_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

  logic [PW-1:0] pre_q;
  logic          tick;
  logic [7:0]    pwm_q, pwm_d;
  logic          ready_q;
  logic          accept;

  dir_t          tgt_dir_q  [2];
  logic [7:0]    tgt_duty_q [2];

  state_t        st_q   [2], st_d   [2];
  dir_t          dir_q  [2], dir_d  [2];
  logic [7:0]    duty_q [2], duty_d [2];
  logic [DW-1:0] dead_q [2], dead_d [2];
  logic [1:0]    en_q, en_d;

  assign tick          = (pre_q == PRE_LAST);
  assign pwm_d         = pwm_q + 8'd1;
  assign accept        = cmd.cmd_valid & ready_q & ~estop;
  assign cmd.cmd_ready = ready_q;
  assign EN            = en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      pwm_q   <= '0;
      ready_q <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        tgt_dir_q[i]  <= D_COAST;
        tgt_duty_q[i] <= '0;
      end
    end else begin
      pre_q   <= tick ? '0 : pre_q + PW'(1);
      pwm_q   <= pwm_d;
      ready_q <= ~estop;
      if (estop) begin
        for (int unsigned i = 0; i < 2; i++) begin
          tgt_dir_q[i]  <= D_COAST;
          tgt_duty_q[i] <= '0;
        end
      end else if (accept) begin
        tgt_dir_q[cmd.cmd_motor]  <= dir_t'(cmd.cmd_dir);
        tgt_duty_q[cmd.cmd_motor] <= cmd.cmd_duty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]   <= STOP;
        dir_q[i]  <= D_COAST;
        duty_q[i] <= '0;
        dead_q[i] <= '0;
      end
      en_q <= '0;
    end else begin
      st_q   <= st_d;
      dir_q  <= dir_d;
      duty_q <= duty_d;
      dead_q <= dead_d;
      en_q   <= en_d;
    end
  end

  // EN is registered from next-state values so it lines up with IN in the same cycle.
  always_comb begin
    en_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      dir_d[i]  = dir_q[i];
      duty_d[i] = duty_q[i];
      dead_d[i] = dead_q[i];

      if (estop) begin
        st_d[i]   = DEAD;
        duty_d[i] = '0;
        dead_d[i] = DEAD_LOAD;
      end else begin
        case (st_q[i])
          STOP: begin
            duty_d[i] = '0;
            if ((tgt_dir_q[i] == D_FWD || tgt_dir_q[i] == D_REV) && tgt_duty_q[i] != 8'd0) begin
              dir_d[i] = tgt_dir_q[i];
              st_d[i]  = RUN;
            end else if (tgt_dir_q[i] == D_BRAKE) begin
              st_d[i] = BRAKE;
            end
          end
          RUN: begin
            if (duty_q[i] == 8'd0 && (tgt_dir_q[i] != dir_q[i] || tgt_duty_q[i] == 8'd0)) begin
              st_d[i]   = DEAD;
              dead_d[i] = DEAD_LOAD;
            end else if (tick) begin
              if (tgt_dir_q[i] == dir_q[i]) begin
                if (duty_q[i] < tgt_duty_q[i])
                  duty_d[i] = duty_q[i] + 8'd1;
                else if (duty_q[i] > tgt_duty_q[i])
                  duty_d[i] = duty_q[i] - 8'd1;
              end else begin
                duty_d[i] = duty_q[i] - 8'd1;
              end
            end
          end
          DEAD: begin
            // Counter holds the remaining dead cycles, so the state lasts exactly DEAD_CYCLES.
            duty_d[i] = '0;
            if (dead_q[i] <= DW'(1)) begin
              st_d[i]   = STOP;
              dead_d[i] = '0;
            end else begin
              dead_d[i] = dead_q[i] - DW'(1);
            end
          end
          BRAKE: begin
            duty_d[i] = '0;
            if (tgt_dir_q[i] != D_BRAKE) begin
              st_d[i]   = DEAD;
              dead_d[i] = DEAD_LOAD;
            end
          end
          default: st_d[i] = STOP;
        endcase
      end

      en_d[i] = (st_d[i] == RUN && pwm_d < duty_d[i]) || (st_d[i] == BRAKE);
    end
  end

  always_comb begin
    IN   = '0;
    busy = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      case (st_q[i])
        RUN:     IN[2*i +: 2] = dir_q[i];
        BRAKE:   IN[2*i +: 2] = 2'b11;
        default: IN[2*i +: 2] = 2'b00;
      endcase
      busy[i] = (st_q[i] == DEAD) ||
                (st_q[i] == RUN && (duty_q[i] != tgt_duty_q[i] || dir_q[i] != tgt_dir_q[i]));
    end
  end

endmodule

// File: tb/tb_motor_sequencer.sv
// Randomized scoreboard bench for motor_sequencer: a reference model predicts the
// outputs after every clock edge, and a monitor compares them against the DUT.
module tb_motor_sequencer;
  localparam int unsigned RD = 4;
  localparam int unsigned DC = 8;
  localparam int COAST = 0, FWD = 1, REV = 2, BRK = 3;
  localparam int M_STOP = 0, M_RUN = 1, M_DEAD = 2, M_BRAKE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       estop = 1'b0;
  logic [3:0] IN;
  logic [1:0] EN;
  logic [1:0] busy;

  motor_sequencer_if cif ();

  motor_sequencer #(.RAMP_DIV(RD), .DEAD_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cif),
    .estop (estop),
    .IN    (IN),
    .EN    (EN),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] in;
    logic [1:0] en;
    logic [1:0] busy;
    logic       rdy;
  } exp_t;
  exp_t expq [$];
  bit   model_on = 0;

  // Reference model: each motor's behaviour in plain integers; time is the edge count k.
  int unsigned m_k;
  bit          m_rdy;
  int          m_mode [2], m_dir [2], m_duty [2], m_dead_end [2], m_tdir [2], m_tduty [2];

  task automatic model_init();
    m_k   = 0;
    m_rdy = 0;
    for (int m = 0; m < 2; m++) begin
      m_mode[m] = M_STOP; m_dir[m] = COAST; m_duty[m] = 0;
      m_dead_end[m] = 0; m_tdir[m] = COAST; m_tduty[m] = 0;
    end
  endtask

  task automatic model_step();
    bit   acc;
    bit   tick;
    int   goal;
    exp_t e;
    m_k  = m_k + 1;
    acc  = cif.cmd_valid && m_rdy && !estop;
    tick = (m_k % RD) == 0;
    for (int m = 0; m < 2; m++) begin
      if (estop) begin
        m_mode[m] = M_DEAD; m_duty[m] = 0; m_dead_end[m] = int'(m_k + DC);
      end else begin
        case (m_mode[m])
          M_STOP:
            if ((m_tdir[m] == FWD || m_tdir[m] == REV) && m_tduty[m] > 0) begin
              m_mode[m] = M_RUN; m_dir[m] = m_tdir[m];
            end else if (m_tdir[m] == BRK) m_mode[m] = M_BRAKE;
          M_RUN:
            if (m_duty[m] == 0 && (m_tdir[m] != m_dir[m] || m_tduty[m] == 0)) begin
              m_mode[m] = M_DEAD; m_dead_end[m] = int'(m_k + DC);
            end else if (tick) begin
              goal = (m_tdir[m] == m_dir[m]) ? m_tduty[m] : 0;
              if (m_duty[m] < goal) m_duty[m]++;
              else if (m_duty[m] > goal) m_duty[m]--;
            end
          M_DEAD:
            if (int'(m_k) >= m_dead_end[m]) m_mode[m] = M_STOP;
          default:
            if (m_tdir[m] != BRK) begin
              m_mode[m] = M_DEAD; m_dead_end[m] = int'(m_k + DC);
            end
        endcase
      end
    end
    if (estop) begin
      for (int m = 0; m < 2; m++) begin m_tdir[m] = COAST; m_tduty[m] = 0; end
    end else if (acc) begin
      m_tdir[cif.cmd_motor]  = int'(cif.cmd_dir);
      m_tduty[cif.cmd_motor] = int'(cif.cmd_duty);
    end
    m_rdy = !estop;

    e.in = '0; e.en = '0; e.busy = '0; e.rdy = m_rdy;
    for (int m = 0; m < 2; m++) begin
      case (m_mode[m])
        M_RUN: begin
          e.in[2*m +: 2] = 2'(m_dir[m]);
          e.en[m]        = (m_k % 256) < m_duty[m];
          e.busy[m]      = (m_duty[m] != m_tduty[m]) || (m_dir[m] != m_tdir[m]);
        end
        M_BRAKE: begin e.in[2*m +: 2] = 2'b11; e.en[m] = 1'b1; end
        M_DEAD:  e.busy[m] = 1'b1;
        default: ;
      endcase
    end
    expq.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if ({IN, EN, busy, cif.cmd_ready} !== {e.in, e.en, e.busy, e.rdy}) begin
        errors++;
        $display("FAIL outputs t=%0t got IN=%b EN=%b busy=%b rdy=%b expected IN=%b EN=%b busy=%b rdy=%b",
                 $time, IN, EN, busy, cif.cmd_ready, e.in, e.en, e.busy, e.rdy);
      end
    end else if (model_on && rst_n) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty t=%0t got no prediction, expected one per cycle", $time);
    end
  end

  // Independent safety check: two different drive states on a bridge are separated by at least DC idle cycles.
  int         zeros [2];
  logic [1:0] last_nz [2];
  logic [1:0] prev [2];
  always @(negedge clk) begin
    logic [1:0] p;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        zeros[m] = 0; last_nz[m] = 2'b00; prev[m] = 2'b00;
      end else begin
        p = IN[2*m +: 2];
        if (p == 2'b00) zeros[m]++;
        else begin
          if (p != prev[m] && last_nz[m] != 2'b00) begin
            checks++;
            if (zeros[m] < int'(DC)) begin
              errors++;
              $display("FAIL dead_gap motor=%0d got %0d idle cycles before IN=%b, required >= %0d", m, zeros[m], p, DC);
            end
          end
          last_nz[m] = p;
          zeros[m]   = 0;
        end
        prev[m] = p;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic mot, input logic [1:0] dir, input logic [7:0] duty, input logic es);
    cif.cmd_valid = v;
    cif.cmd_motor = mot;
    cif.cmd_dir   = dir;
    cif.cmd_duty  = duty;
    estop         = es;
    if (model_on) model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 8'd0, 1'b0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_init();
    model_on = 1;
    idle(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t got no finish, expected bench to end", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    cif.cmd_valid = 1'b0; cif.cmd_motor = 1'b0; cif.cmd_dir = 2'b00; cif.cmd_duty = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, IN, EN, cif.cmd_ready}, 32'd0);
    chk("reset_busy", {30'd0, busy}, 32'd0);
    release_reset();
    idle(3);

    // forward ramp then PWM duty measurement
    cyc(1'b1, 1'b0, 2'(FWD), 8'd8, 1'b0);
    idle(45);
    en_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      en_cnt += int'(EN[0]);
    end
    chk("pwm_high_count", 32'(en_cnt), 32'd8);

    // reversal through dead time
    cyc(1'b1, 1'b0, 2'(REV), 8'd8, 1'b0);
    idle(90);

    // brake then coast on motor B
    cyc(1'b1, 1'b1, 2'(FWD), 8'd4, 1'b0);
    idle(30);
    cyc(1'b1, 1'b1, 2'(BRK), 8'd0, 1'b0);
    idle(40);
    chk("brake_pins", {28'd0, IN[3:2], EN[1], 1'b0}, {28'd0, 2'b11, 1'b1, 1'b0});
    cyc(1'b1, 1'b1, 2'(COAST), 8'd0, 1'b0);
    idle(20);

    // estop mid-ramp
    cyc(1'b1, 1'b0, 2'(FWD), 8'd20, 1'b0);
    cyc(1'b1, 1'b1, 2'(REV), 8'd20, 1'b0);
    idle(20);
    cyc(1'b0, 1'b0, 2'b00, 8'd0, 1'b1);
    chk("estop_outputs", {26'd0, IN, EN}, 32'd0);
    cyc(1'b1, 1'b1, 2'(FWD), 8'd9, 1'b1);
    cyc(1'b0, 1'b0, 2'b00, 8'd0, 1'b1);
    idle(12);
    cyc(1'b1, 1'b0, 2'(FWD), 8'd5, 1'b0);
    idle(30);

    // back-to-back commands, retarget, async reset mid-ramp
    cyc(1'b1, 1'b0, 2'(FWD), 8'd10, 1'b0);
    cyc(1'b1, 1'b1, 2'(FWD), 8'd12, 1'b0);
    idle(16);
    cyc(1'b1, 1'b0, 2'(FWD), 8'd3, 1'b0);
    idle(10);
    model_on = 0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {25'd0, IN, EN, cif.cmd_ready}, 32'd0);
    repeat (2) @(negedge clk);
    release_reset();
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      cyc(r < 30, 1'($urandom), 2'($urandom), 8'($urandom_range(0, 24)), r >= 198);
    end
    idle(150);

    model_on = 0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
